// File: rtl/ecall_controller.sv
// ecall_controller
// Multi-cycle sequencer for environment-call service requests coming from a
// single-cycle core. When the decoder flags an ecall, the PC is frozen, the
// service code in a7 is decoded and the service is carried out:
//   a7 == 1  : print a0 on the display, wait for the confirm button
//   a7 == 5  : wait for confirm, then write the switch value into a0
//   a7 == 10 : halt the core until reset
//   a7 == 11 : restart the core (one-cycle pc_change strobe)
//   other    : no-op, the ecall simply retires
//
// Optional build macro ECALL_PRINT_TIMEOUT_EN: when defined, a print also
// releases the core on its own after PRINT_HOLD cycles without confirm.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   ecall      high while the current instruction is ecall
//   a7         service code (x17)
//   a0         service argument (x10)
//   io_input   switch value
//   confirm    debounced single-cycle button pulse
//   stall      freezes PC update (combinational)
//   rf_we      register-file side-write enable (one-cycle pulse)
//   rf_waddr   side-write address
//   rf_wdata   side-write data
//   disp_en    display-valid flag
//   disp_data  value shown on the display
//   led_out    status LEDs: [7] read pending, [0] halted, [6:1] always 0
//   pc_change  one-cycle PC restart strobe
//   halted     core halted

module ecall_controller #(
    parameter int PRINT_HOLD = 50000000,
    parameter int CNT_W      = 26,
    parameter int A0_IDX     = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ecall,
    input  logic [31:0] a7,
    input  logic [31:0] a0,
    input  logic [31:0] io_input,
    input  logic        confirm,
    output logic        stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        disp_en,
    output logic [31:0] disp_data,
    output logic [7:0]  led_out,
    output logic        pc_change,
    output logic        halted
);

    typedef enum logic [2:0] {
        IDLE,
        PRINT,
        READ,
        HALT,
        RESTART,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic   led_read;
    logic   led_halt;

    // The timeout counter must be able to hold PRINT_HOLD-1.
    generate
        if (64'(PRINT_HOLD) >= (64'd1 << CNT_W)) begin : g_bad_cfg
            $error("ecall_controller: CNT_W too small for PRINT_HOLD");
        end
    endgenerate

`ifdef ECALL_PRINT_TIMEOUT_EN
    logic [CNT_W-1:0] print_cnt;
    logic             print_timeout;

    assign print_timeout = (print_cnt == CNT_W'(PRINT_HOLD - 1));

    // Counter sits at zero outside PRINT so it starts from zero on every
    // entry, then counts each PRINT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            print_cnt <= '0;
        end else if (state == PRINT) begin
            print_cnt <= print_cnt + 1'b1;
        end else begin
            print_cnt <= '0;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode. The service code is decoded in the same IDLE cycle
    // that sees ecall; DONE ignores ecall so the same instruction cannot
    // retrigger while the PC steps past it.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (ecall) begin
                    case (a7)
                        32'd1:   next_state = PRINT;
                        32'd5:   next_state = READ;
                        32'd10:  next_state = HALT;
                        32'd11:  next_state = RESTART;
                        default: next_state = DONE;
                    endcase
                end
            end
            PRINT: begin
                if (confirm) begin
                    next_state = DONE;
                end
`ifdef ECALL_PRINT_TIMEOUT_EN
                else if (print_timeout) begin
                    next_state = DONE;
                end
`endif
            end
            READ: begin
                if (confirm) begin
                    next_state = DONE;
                end
            end
            HALT:    next_state = HALT;
            RESTART: next_state = IDLE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Stall covers the decode cycle itself so the PC never moves past an
    // ecall before the service has been chosen.
    assign stall = ((state == IDLE) && ecall) ||
                   (state == PRINT) || (state == READ) || (state == HALT);

    assign led_out = {led_read, 6'b000000, led_halt};

    // Registered side effects. Entry effects are keyed on the IDLE decode so
    // they are visible in the first cycle of the service state; the read
    // write-back fires on the confirm edge and is therefore seen in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            disp_en   <= 1'b0;
            disp_data <= '0;
            led_read  <= 1'b0;
            led_halt  <= 1'b0;
            pc_change <= 1'b0;
            halted    <= 1'b0;
        end else begin
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            pc_change <= (state == IDLE) && (next_state == RESTART);

            if ((state == IDLE) && (next_state == PRINT)) begin
                disp_data <= a0;
                disp_en   <= 1'b1;
            end

            if ((state == IDLE) && (next_state == READ)) begin
                led_read <= 1'b1;
            end

            if ((state == IDLE) && (next_state == HALT)) begin
                led_halt <= 1'b1;
                halted   <= 1'b1;
            end

            if ((state == READ) && confirm) begin
                rf_we    <= 1'b1;
                rf_waddr <= 5'(A0_IDX);
                rf_wdata <= io_input;
                led_read <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ecall_controller.sv
// tb_ecall_controller
// Directed self-checking bench for ecall_controller. The DUT is built with a
// short PRINT_HOLD so the optional print timeout (ECALL_PRINT_TIMEOUT_EN)
// can be exercised in a few cycles; without the macro the print is checked
// to wait indefinitely instead.

module tb_ecall_controller;

    logic        clk;
    logic        reset;
    logic        ecall;
    logic [31:0] a7;
    logic [31:0] a0;
    logic [31:0] io_input;
    logic        confirm;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        disp_en;
    logic [31:0] disp_data;
    logic [7:0]  led_out;
    logic        pc_change;
    logic        halted;

    int checks;
    int errors;

    ecall_controller #(
        .PRINT_HOLD (8),
        .CNT_W      (4),
        .A0_IDX     (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ecall     (ecall),
        .a7        (a7),
        .a0        (a0),
        .io_input  (io_input),
        .confirm   (confirm),
        .stall     (stall),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .disp_en   (disp_en),
        .disp_data (disp_data),
        .led_out   (led_out),
        .pc_change (pc_change),
        .halted    (halted)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive all core/board inputs at once.
    task automatic applyStimulus(input logic e, input logic [31:0] code,
                                 input logic [31:0] arg, input logic [31:0] sw,
                                 input logic conf);
        ecall    = e;
        a7       = code;
        a0       = arg;
        io_input = sw;
        confirm  = conf;
        #1;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        int bad_cycles;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_disp_en", 32'(disp_en), 32'd0);
        checkOutput("rst_disp_data", disp_data, 32'd0);
        checkOutput("rst_led", 32'(led_out), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_rf_we", 32'(rf_we), 32'd0);
        checkOutput("rst_pc_change", 32'(pc_change), 32'd0);

        // Print service with confirm after 10 cycles
        applyStimulus(1'b1, 32'd1, 32'h0000ABCD, 32'd0, 1'b0);
        checkOutput("print_decode_stall", 32'(stall), 32'd1);
        tick();
        checkOutput("print_stall", 32'(stall), 32'd1);
        checkOutput("print_disp_data", disp_data, 32'h0000ABCD);
        checkOutput("print_disp_en", 32'(disp_en), 32'd1);
        for (int i = 0; i < 9; i++) tick();
        checkOutput("print_wait_stall", 32'(stall), 32'd1);
        applyStimulus(1'b1, 32'd1, 32'h0000ABCD, 32'd0, 1'b1);
        tick();
        applyStimulus(1'b1, 32'd1, 32'h0000ABCD, 32'd0, 1'b0);
        checkOutput("print_done_stall", 32'(stall), 32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        tick();
        checkOutput("print_idle_stall", 32'(stall), 32'd0);
        checkOutput("print_keep_data", disp_data, 32'h0000ABCD);
        checkOutput("print_keep_en", 32'(disp_en), 32'd1);

        // Read service; confirm coincident with entry must be ignored
        applyStimulus(1'b1, 32'd5, 32'd0, 32'h12345678, 1'b1);
        tick();
        applyStimulus(1'b1, 32'd5, 32'd0, 32'h12345678, 1'b0);
        checkOutput("read_led", 32'(led_out), 32'h80);
        checkOutput("read_stall", 32'(stall), 32'd1);
        checkOutput("read_entry_rf_we", 32'(rf_we), 32'd0);
        tick();
        checkOutput("read_hold_stall", 32'(stall), 32'd1);
        checkOutput("read_hold_rf_we", 32'(rf_we), 32'd0);
        applyStimulus(1'b1, 32'd5, 32'd0, 32'h12345678, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0);
        checkOutput("read_rf_we", 32'(rf_we), 32'd1);
        checkOutput("read_rf_waddr", 32'(rf_waddr), 32'd10);
        checkOutput("read_rf_wdata", rf_wdata, 32'h12345678);
        checkOutput("read_led_clear", 32'(led_out), 32'h00);
        checkOutput("read_done_stall", 32'(stall), 32'd0);
        tick();
        checkOutput("read_rf_we_after", 32'(rf_we), 32'd0);

        // Restart service
        applyStimulus(1'b1, 32'd11, 32'd0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("restart_pc_change", 32'(pc_change), 32'd1);
        checkOutput("restart_stall", 32'(stall), 32'd0);
        tick();
        checkOutput("restart_pc_change_off", 32'(pc_change), 32'd0);

        // Unknown code: one DONE cycle, ecall still high is ignored there
        applyStimulus(1'b1, 32'd7, 32'd0, 32'd0, 1'b0);
        tick();
        checkOutput("unk_done_stall", 32'(stall), 32'd0);
        checkOutput("unk_led", 32'(led_out), 32'h00);
        checkOutput("unk_rf_we", 32'(rf_we), 32'd0);
        checkOutput("unk_pc_change", 32'(pc_change), 32'd0);
        checkOutput("unk_disp_data", disp_data, 32'h0000ABCD);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("unk_idle_stall", 32'(stall), 32'd0);
        tick();

        // Reset while waiting in READ, with confirm high during reset
        applyStimulus(1'b1, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0);
        tick();
        checkOutput("rread_led", 32'(led_out), 32'h80);
        reset = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0, 32'hDEADBEEF, 1'b1);
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("rread_led_clear", 32'(led_out), 32'h00);
        checkOutput("rread_rf_we", 32'(rf_we), 32'd0);
        checkOutput("rread_stall", 32'(stall), 32'd0);
        checkOutput("rread_disp_data", disp_data, 32'd0);
        tick();
        checkOutput("rread_rf_we_after", 32'(rf_we), 32'd0);

        // Print without confirm: timeout or indefinite wait
        applyStimulus(1'b1, 32'd1, 32'h00000042, 32'd0, 1'b0);
        tick();
        checkOutput("pto_entry_stall", 32'(stall), 32'd1);
`ifdef ECALL_PRINT_TIMEOUT_EN
        for (int i = 0; i < 7; i++) tick();
        checkOutput("pto_before_stall", 32'(stall), 32'd1);
        tick();
        checkOutput("pto_done_stall", 32'(stall), 32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        tick();
`else
        for (int i = 0; i < 100; i++) tick();
        checkOutput("pto_still_print", 32'(stall), 32'd1);
        applyStimulus(1'b1, 32'd1, 32'h00000042, 32'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("pto_done_stall", 32'(stall), 32'd0);
        tick();
`endif
        checkOutput("pto_disp_data", disp_data, 32'h00000042);

        // Halt service holds through confirm pulses until reset
        applyStimulus(1'b1, 32'd10, 32'd0, 32'd0, 1'b0);
        tick();
        checkOutput("halt_halted", 32'(halted), 32'd1);
        checkOutput("halt_led", 32'(led_out), 32'h01);
        checkOutput("halt_stall", 32'(stall), 32'd1);
        bad_cycles = 0;
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, (i % 50) == 7);
            tick();
            if (!(stall === 1'b1 && halted === 1'b1 && led_out === 8'h01 &&
                  pc_change === 1'b0))
                bad_cycles++;
        end
        checkOutput("halt_held_cycles", 32'(bad_cycles), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checkOutput("halt_rst_halted", 32'(halted), 32'd0);
        checkOutput("halt_rst_led", 32'(led_out), 32'h00);
        checkOutput("halt_rst_stall", 32'(stall), 32'd0);
        checkOutput("halt_rst_disp_en", 32'(disp_en), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ecall_controller.md
Name: ecall_controller

Overview:
- Multi-cycle sequencer for environment-call service requests from the single-cycle core.
- On an ecall instruction, it stalls the PC, decodes the service code in a7, and performs the service: print a0, read switches into a0, halt, or restart.
- Handshakes with the board confirm button, then releases the core.
- It owns the register-file side-write of a0 and the LED/display/pc_change strobes.

Parameters:
- PRINT_HOLD, 50000000: print auto-release timeout in cycles; used only with the optional feature.
- CNT_W, 26: timeout counter width; must satisfy 2^CNT_W > PRINT_HOLD.
- A0_IDX, 10: register index written by the read service.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ecall  in  1  decoder flag; high while the current instruction is ecall.
- a7  in  32  current value of x17, the service code.
- a0  in  32  current value of x10, the service argument.
- io_input  in  32  switch value.
- confirm  in  1  debounced single-cycle button pulse.
- stall  out  1  freezes PC update when high.
- rf_we  out  1  register-file side-write enable.
- rf_waddr  out  5  side-write address.
- rf_wdata  out  32  side-write data.
- disp_en  out  1  display-valid flag.
- disp_data  out  32  value shown on the display.
- led_out  out  8  status LEDs.
- pc_change  out  1  one-cycle PC restart strobe.
- halted  out  1  core halted.

Behaviour:
- States: IDLE, PRINT, READ, HALT, RESTART, DONE. State and all registered outputs update on the rising edge of clk.
- Reset, from any state including mid-service:
  - state=IDLE.
  - stall=0, rf_we=0, rf_waddr=0, rf_wdata=0.
  - disp_en=0, disp_data=0, led_out=0, pc_change=0, halted=0.
  - Timeout counter=0.
- stall is combinational:
  - 1 when (state==IDLE && ecall), or state is PRINT, READ or HALT.
  - 0 in DONE and RESTART.
- IDLE, with ecall=1, decodes a7 in the same cycle:
  - a7==1 → PRINT. Latch disp_data<=a0, disp_en<=1.
  - a7==5 → READ. led_out[7]<=1.
  - a7==10 → HALT. led_out[0]<=1, halted<=1.
  - a7==11 → RESTART.
  - Any other a7 → DONE (treated as a no-op).
- IDLE, with ecall=0: stay in IDLE. confirm is ignored.
- PRINT:
  - Wait for confirm=1, then → DONE.
  - disp_data and disp_en persist after exit, until the next print or reset.
- READ:
  - On confirm=1 in that cycle: rf_we=1, rf_waddr=A0_IDX, rf_wdata=io_input sampled that cycle, all for exactly one cycle.
  - Same cycle: led_out[7]<=0, → DONE.
  - rf_we is 0 in every other cycle.
- HALT: terminal; exits only on reset. stall=1 and halted=1 are held.
- RESTART:
  - pc_change=1 for exactly one cycle, stall=0, → IDLE.
  - The PC unit gives pc_change priority over stall.
- DONE:
  - One cycle with stall=0, so the PC advances past the ecall.
  - ecall is ignored in this cycle, which prevents re-triggering on the same instruction. → IDLE.
- confirm is sampled only in PRINT and READ. A confirm coincident with entry (the IDLE cycle) is ignored.
- Latency:
  - Print and read services complete 1 cycle after confirm; the ecall retires 2 cycles after confirm.
  - Unknown codes retire 2 cycles after ecall.
- led_out bits [6:1] are always 0. led_out[0] stays 1 until reset.

Optional Feature:
- Macro: ECALL_PRINT_TIMEOUT_EN.
- Defined:
  - PRINT also exits to DONE when the timeout counter reaches PRINT_HOLD-1.
  - The counter clears on PRINT entry and increments each PRINT cycle. confirm still exits early.
  - Exit occurs PRINT_HOLD cycles after entry if there is no confirm.
- Undefined: no counter logic; PRINT waits indefinitely for confirm.

Test Plan:
- a7=1, a0=0x0000ABCD, ecall=1 → stall=1, disp_data=0x0000ABCD, disp_en=1. Confirm pulse 10 cycles later → next cycle DONE with stall=0, then IDLE. disp_data still 0x0000ABCD.
- a7=5, io_input=0x12345678, ecall → led_out[7]=1, stall=1. Confirm → one-cycle rf_we=1, rf_waddr=10, rf_wdata=0x12345678, led_out[7]=0. rf_we=0 afterwards.
- a7=10, ecall → halted=1, led_out=0x01, stall=1 held for 1000 cycles despite confirm pulses. Reset → all outputs 0, IDLE.
- a7=11, ecall → pc_change=1 for exactly one cycle, stall=0. a7=7, ecall → one DONE cycle, no side effects, ecall still high in DONE causes no retrigger.
- Reset asserted while in READ → next cycle IDLE, led_out=0, rf_we never pulses.
- With ECALL_PRINT_TIMEOUT_EN, PRINT_HOLD=8: print with no confirm → DONE exactly 8 cycles after entry. Without the macro → still in PRINT after 100 cycles.
